// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: internal opcodes,
// ROB tag width, the null operand value and the CDB tag-match helper.
package alu_rs_pkg;

  localparam int RBID        = 4;
  localparam int RS_SIZE_DEF = 16;
  localparam logic [31:0] NULL32 = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_SLL   = 6'd3,
    OP_SLT   = 6'd4,
    OP_SLTU  = 6'd5,
    OP_XOR   = 6'd6,
    OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,
    OP_OR    = 6'd9,
    OP_AND   = 6'd10,
    OP_ADDI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_SLTIU = 6'd13,
    OP_XORI  = 6'd14,
    OP_ORI   = 6'd15,
    OP_ANDI  = 6'd16,
    OP_SLLI  = 6'd17,
    OP_SRLI  = 6'd18,
    OP_SRAI  = 6'd19,
    OP_LUI   = 6'd20,
    OP_AUIPC = 6'd21,
    OP_BEQ   = 6'd22,
    OP_BNE   = 6'd23,
    OP_BLT   = 6'd24,
    OP_BGE   = 6'd25,
    OP_BLTU  = 6'd26,
    OP_BGEU  = 6'd27,
    OP_JAL   = 6'd28,
    OP_JALR  = 6'd29
  } alu_op_e;

  function automatic logic cdb_hit(input logic valid,
                                   input logic [RBID-1:0] cdb_tag,
                                   input logic [RBID-1:0] wait_tag);
    return valid && (cdb_tag == wait_tag);
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Find-first-set priority encoder: lowest set bit of req wins.
module rs_select #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest-index request is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched micro-ops,
// snoops both CDBs for operands and issues one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = RBID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_in,
  input  logic             clr,
  input  logic             dsp_valid,
  input  logic [5:0]       dsp_opcode,
  input  logic [31:0]      dsp_vj,
  input  logic [31:0]      dsp_vk,
  input  logic             dsp_qj_p,
  input  logic             dsp_qk_p,
  input  logic [ROB_W-1:0] dsp_qj,
  input  logic [ROB_W-1:0] dsp_qk,
  input  logic [ROB_W-1:0] dsp_rob,
  output logic             full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             alu_flag,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [5:0]       alu_opcode,
  output logic [ROB_W-1:0] alu_rob
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_p;
  logic [RS_SIZE-1:0] qk_p;
  logic [5:0]         opcode [RS_SIZE];
  logic [31:0]        vj     [RS_SIZE];
  logic [31:0]        vk     [RS_SIZE];
  logic [ROB_W-1:0]   qj     [RS_SIZE];
  logic [ROB_W-1:0]   qk     [RS_SIZE];
  logic [ROB_W-1:0]   rob    [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] free_vec;
  logic [IDX_W-1:0]   ready_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               ready_valid;
  logic               free_valid;

  logic [31:0] in_vj;
  logic [31:0] in_vk;
  logic        in_qj_p;
  logic        in_qk_p;

  assign ready_vec = busy & ~qj_p & ~qk_p;
  assign free_vec  = ~busy;
  assign full      = &busy;

  rs_select #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
    .req   (free_vec),
    .idx   (free_idx),
    .valid (free_valid)
  );

  rs_select #(.N(RS_SIZE), .W(IDX_W)) u_ready_sel (
    .req   (ready_vec),
    .idx   (ready_idx),
    .valid (ready_valid)
  );

  // Dispatch bypass: an operand whose producer broadcasts this very cycle is stored resolved.
  always_comb begin
    in_vj   = dsp_vj;
    in_qj_p = dsp_qj_p;
    in_vk   = dsp_vk;
    in_qk_p = dsp_qk_p;
    if (dsp_qj_p) begin
      if (cdb_hit(alu_cdb_valid, alu_cdb_rob, dsp_qj)) begin
        in_vj   = alu_cdb_val;
        in_qj_p = 1'b0;
      end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob, dsp_qj)) begin
        in_vj   = lsb_cdb_val;
        in_qj_p = 1'b0;
      end
    end
    if (dsp_qk_p) begin
      if (cdb_hit(alu_cdb_valid, alu_cdb_rob, dsp_qk)) begin
        in_vk   = alu_cdb_val;
        in_qk_p = 1'b0;
      end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob, dsp_qk)) begin
        in_vk   = lsb_cdb_val;
        in_qk_p = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      qj_p       <= '0;
      qk_p       <= '0;
      alu_flag   <= 1'b0;
      alu_val1   <= NULL32;
      alu_val2   <= NULL32;
      alu_opcode <= '0;
      alu_rob    <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        opcode[i] <= '0;
        vj[i]     <= '0;
        vk[i]     <= '0;
        qj[i]     <= '0;
        qk[i]     <= '0;
        rob[i]    <= '0;
      end
    end else if (!rdy_in) begin
      alu_flag <= 1'b0;
    end else if (clr) begin
      busy     <= '0;
      alu_flag <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_p[i]) begin
          if (cdb_hit(alu_cdb_valid, alu_cdb_rob, qj[i])) begin
            vj[i]   <= alu_cdb_val;
            qj_p[i] <= 1'b0;
          end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob, qj[i])) begin
            vj[i]   <= lsb_cdb_val;
            qj_p[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_p[i]) begin
          if (cdb_hit(alu_cdb_valid, alu_cdb_rob, qk[i])) begin
            vk[i]   <= alu_cdb_val;
            qk_p[i] <= 1'b0;
          end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob, qk[i])) begin
            vk[i]   <= lsb_cdb_val;
            qk_p[i] <= 1'b0;
          end
        end
      end

      if (ready_valid) begin
        alu_flag        <= 1'b1;
        alu_val1        <= vj[ready_idx];
        alu_val2        <= vk[ready_idx];
        alu_opcode      <= opcode[ready_idx];
        alu_rob         <= rob[ready_idx];
        busy[ready_idx] <= 1'b0;
      end else begin
        alu_flag <= 1'b0;
        alu_val1 <= NULL32;
        alu_val2 <= NULL32;
      end

      // The free slot was empty before the edge, so it never collides with the issued slot.
      if (dsp_valid && !full && free_valid) begin
        busy[free_idx]   <= 1'b1;
        opcode[free_idx] <= dsp_opcode;
        vj[free_idx]     <= in_vj;
        vk[free_idx]     <= in_vk;
        qj_p[free_idx]   <= in_qj_p;
        qk_p[free_idx]   <= in_qk_p;
        qj[free_idx]     <= dsp_qj;
        qk[free_idx]     <= dsp_qk;
        rob[free_idx]    <= dsp_rob;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs with hand-computed expectations.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk;
  logic        rst;
  logic        rdy_in;
  logic        clr;
  logic        dsp_valid;
  logic [5:0]  dsp_opcode;
  logic [31:0] dsp_vj;
  logic [31:0] dsp_vk;
  logic        dsp_qj_p;
  logic        dsp_qk_p;
  logic [3:0]  dsp_qj;
  logic [3:0]  dsp_qk;
  logic [3:0]  dsp_rob;
  logic        full;
  logic        alu_cdb_valid;
  logic [3:0]  alu_cdb_rob;
  logic [31:0] alu_cdb_val;
  logic        lsb_cdb_valid;
  logic [3:0]  lsb_cdb_rob;
  logic [31:0] lsb_cdb_val;
  logic        alu_flag;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [5:0]  alu_opcode;
  logic [3:0]  alu_rob;

  int total = 0;
  int bad   = 0;

  alu_rs #(.RS_SIZE(16), .ROB_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy_in        (rdy_in),
    .clr           (clr),
    .dsp_valid     (dsp_valid),
    .dsp_opcode    (dsp_opcode),
    .dsp_vj        (dsp_vj),
    .dsp_vk        (dsp_vk),
    .dsp_qj_p      (dsp_qj_p),
    .dsp_qk_p      (dsp_qk_p),
    .dsp_qj        (dsp_qj),
    .dsp_qk        (dsp_qk),
    .dsp_rob       (dsp_rob),
    .full          (full),
    .alu_cdb_valid (alu_cdb_valid),
    .alu_cdb_rob   (alu_cdb_rob),
    .alu_cdb_val   (alu_cdb_val),
    .lsb_cdb_valid (lsb_cdb_valid),
    .lsb_cdb_rob   (lsb_cdb_rob),
    .lsb_cdb_val   (lsb_cdb_val),
    .alu_flag      (alu_flag),
    .alu_val1      (alu_val1),
    .alu_val2      (alu_val2),
    .alu_opcode    (alu_opcode),
    .alu_rob       (alu_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dsp_valid     = 1'b0;
    dsp_opcode    = '0;
    dsp_vj        = '0;
    dsp_vk        = '0;
    dsp_qj_p      = 1'b0;
    dsp_qk_p      = 1'b0;
    dsp_qj        = '0;
    dsp_qk        = '0;
    dsp_rob       = '0;
    alu_cdb_valid = 1'b0;
    alu_cdb_rob   = '0;
    alu_cdb_val   = '0;
    lsb_cdb_valid = 1'b0;
    lsb_cdb_rob   = '0;
    lsb_cdb_val   = '0;
  endtask

  task automatic set_dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic qjp, input logic [3:0] qj, input logic qkp,
                              input logic [3:0] qk, input logic [3:0] rob);
    dsp_valid  = 1'b1;
    dsp_opcode = op;
    dsp_vj     = vj;
    dsp_vk     = vk;
    dsp_qj_p   = qjp;
    dsp_qj     = qj;
    dsp_qk_p   = qkp;
    dsp_qk     = qk;
    dsp_rob    = rob;
  endtask

  initial begin
    rst    = 1'b1;
    rdy_in = 1'b1;
    clr    = 1'b0;
    idle_inputs();

    // Reset state
    #12;
    chk("rst_flag", alu_flag, 0);
    chk("rst_val1", alu_val1, 0);
    chk("rst_val2", alu_val2, 0);
    chk("rst_op", alu_opcode, 0);
    chk("rst_rob", alu_rob, 0);
    chk("rst_full", full, 0);
    rst = 1'b0;

    // Ready ADD: issues after the second edge, then a single-cycle pulse
    tick();
    set_dispatch(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    idle_inputs();
    chk("add_e0_flag", alu_flag, 0);
    tick();
    chk("add_flag", alu_flag, 1);
    chk("add_val1", alu_val1, 5);
    chk("add_val2", alu_val2, 7);
    chk("add_rob", alu_rob, 3);
    chk("add_op", alu_opcode, OP_ADD);
    tick();
    chk("add_pulse", alu_flag, 0);
    chk("add_null1", alu_val1, 0);
    chk("add_hold_rob", alu_rob, 3);

    // SUB waiting on tag 2, woken by LSB CDB
    set_dispatch(OP_SUB, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    tick();
    idle_inputs();
    tick();
    chk("sub_wait", alu_flag, 0);
    lsb_cdb_valid = 1'b1;
    lsb_cdb_rob   = 4'd2;
    lsb_cdb_val   = 32'h100;
    tick();
    idle_inputs();
    chk("sub_wake_edge", alu_flag, 0);
    tick();
    chk("sub_flag", alu_flag, 1);
    chk("sub_val1", alu_val1, 32'h100);
    chk("sub_val2", alu_val2, 3);
    chk("sub_op", alu_opcode, OP_SUB);
    chk("sub_rob", alu_rob, 4);

    // Dispatch bypass on qk from the ALU CDB
    tick();
    set_dispatch(OP_XOR, 32'd4, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd7);
    alu_cdb_valid = 1'b1;
    alu_cdb_rob   = 4'd6;
    alu_cdb_val   = 32'd9;
    tick();
    idle_inputs();
    chk("byp_e0", alu_flag, 0);
    tick();
    chk("byp_flag", alu_flag, 1);
    chk("byp_val1", alu_val1, 4);
    chk("byp_val2", alu_val2, 9);
    chk("byp_rob", alu_rob, 7);

    // Fill all 16 entries waiting on tag 1
    tick();
    for (int i = 0; i < 16; i++) begin
      set_dispatch(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle_inputs();
    chk("fill_full", full, 1);
    chk("fill_flag", alu_flag, 0);
    set_dispatch(OP_OR, 32'd1, 32'd99, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick();
    idle_inputs();
    chk("drop_full", full, 1);
    lsb_cdb_valid = 1'b1;
    lsb_cdb_rob   = 4'd1;
    lsb_cdb_val   = 32'h55;
    tick();
    idle_inputs();
    chk("fill_wake_edge", alu_flag, 0);
    chk("fill_wake_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_flag", alu_flag, 1);
      chk("drain_rob", alu_rob, 32'(i));
      chk("drain_val1", alu_val1, 32'h55);
      chk("drain_val2", alu_val2, 32'(i));
      if (i == 0) chk("drain_full", full, 0);
    end
    tick();
    chk("drop_no_issue", alu_flag, 0);

    // Flush four pending entries
    for (int i = 0; i < 4; i++) begin
      set_dispatch(OP_AND, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'(i + 8));
      tick();
    end
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_flag", alu_flag, 0);
    chk("clr_full", full, 0);
    alu_cdb_valid = 1'b1;
    alu_cdb_rob   = 4'd2;
    alu_cdb_val   = 32'd7;
    tick();
    idle_inputs();
    tick();
    chk("clr_no_issue1", alu_flag, 0);
    tick();
    chk("clr_no_issue2", alu_flag, 0);
    set_dispatch(OP_ADD, 32'd11, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick();
    idle_inputs();
    tick();
    chk("post_clr_flag", alu_flag, 1);
    chk("post_clr_val1", alu_val1, 11);
    chk("post_clr_rob", alu_rob, 9);

    // Asynchronous reset while an issue is on the outputs
    tick();
    set_dispatch(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    tick();
    set_dispatch(OP_SLT, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd6);
    tick();
    idle_inputs();
    chk("pre_rst_flag", alu_flag, 1);
    chk("pre_rst_val1", alu_val1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_flag", alu_flag, 0);
    chk("async_val1", alu_val1, 0);
    chk("async_rob", alu_rob, 0);
    #1;
    rst = 1'b0;
    alu_cdb_valid = 1'b1;
    alu_cdb_rob   = 4'd3;
    alu_cdb_val   = 32'd1;
    tick();
    idle_inputs();
    tick();
    chk("rst_empty1", alu_flag, 0);
    tick();
    chk("rst_empty2", alu_flag, 0);
    chk("rst_empty_full", full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU in the out-of-order RISC-V core. It buffers dispatched ALU/branch/JALR micro-ops and snoops both CDB ports to capture operand values. Each cycle it issues one ready entry to the combinational ALU over the `flag`/`val1`/`val2`/`opcode`/`rob_reorder` interface. It is the producer side of the ALU input interface, and its wakeup logic is the consumer of the ALU result broadcast.

## Interface
Parameters:
- `RS_SIZE`, 16: number of entries (power of two)
- `ROB_W`, 4: ROB tag width, must match `` `RBID``

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `rdy_in` in 1: global enable; low freezes all entries
- `clr` in 1: synchronous flush on misprediction
- `dsp_valid` in 1: dispatch request this cycle
- `dsp_opcode` in 6: internal opcode (`` `ADD``…`` `JALR``)
- `dsp_vj`, `dsp_vk` in 32: operand values, meaningful when the matching pending bit is 0
- `dsp_qj_p`, `dsp_qk_p` in 1: operand pending
- `dsp_qj`, `dsp_qk` in ROB_W: producer ROB tags
- `dsp_rob` in ROB_W: destination ROB tag
- `full` out 1: no free entry
- `alu_cdb_valid` in 1, `alu_cdb_rob` in ROB_W, `alu_cdb_val` in 32: ALU broadcast
- `lsb_cdb_valid` in 1, `lsb_cdb_rob` in ROB_W, `lsb_cdb_val` in 32: LSB broadcast
- `alu_flag` out 1: issue valid
- `alu_val1`, `alu_val2` out 32: issued operands
- `alu_opcode` out 6: issued opcode
- `alu_rob` out ROB_W: issued ROB tag

## Operation
- Each entry holds: busy, opcode, vj, vk, qj_p, qk_p, qj, qk, rob.
- Dispatch: on an edge with `dsp_valid && rdy_in && !clr && !full`, the lowest-index free entry is written. `dsp_valid` while `full` is dropped; the dispatcher must not do this.
- Dispatch bypass: if an incoming operand is pending and either CDB is valid with a matching tag in the same cycle, the entry stores the CDB value with pending=0.
- Wakeup: each edge, every busy entry with a pending operand whose tag matches a valid CDB captures that CDB's value and clears its pending bit. Both CDBs may wake different operands of the same entry in one cycle. If both CDBs carry the same tag, the ALU CDB wins; this is illegal upstream.
- Ready = busy && !qj_p && !qk_p, evaluated on registered state only. A same-cycle wakeup becomes issuable the next cycle.
- Select: the lowest-index ready entry. On the edge, its fields load the output registers, `alu_flag` is set to 1, and the entry is freed.
- No ready entry: `alu_flag` is 0; `alu_val1`/`alu_val2` are 0 (`` `null32``) and the other fields hold.
- `clr` (with `rdy_in`): all busy bits clear and `alu_flag` goes to 0 at the edge. Dispatch and wakeup in that cycle are ignored.
- `rdy_in` low: entries and outputs other than `alu_flag` hold; `alu_flag` registers 0.
- `full` = all busy bits set, combinational from registered state. It does not account for a same-cycle issue (conservative).

## Timing
- Reset (async): all busy bits 0, `alu_flag`=0, `alu_val1`=`alu_val2`=0, `alu_opcode`=0, `alu_rob`=0, `full`=0.
- Minimum latency: dispatch of a ready op at edge E0 gives `alu_flag` high after E1. The ALU result is on the ALU CDB in the same cycle.
- Dependent op: producer issued after E1 broadcasts during cycle E1–E2. The waiter wakes at E2 and issues at E3, so back-to-back dependents are one bubble apart.
- `alu_flag` is a single-cycle pulse per entry. One issue per cycle at most.
- Simultaneous dispatch and issue into the same freed slot is not allowed. Dispatch uses only entries free before the edge.
- Reset asserted mid-operation discards all entries immediately. There is no partial state.

## Structure
- `defines.v` supplies: internal opcodes, `` `RBID``, `` `null32``, `RS_SIZE`.
- Sub-module `rs_select`: parameterised find-first-set priority encoder with a valid output. It is instantiated twice: once for the free slot, once for the ready entry.
- Entry array and wakeup loop live in `alu_rs`.

## Test plan
- Reset, then dispatch `ADD` with vj=5, vk=7, both ready, rob=3 → after 2 edges `alu_flag`=1, `alu_val1`=5, `alu_val2`=7, `alu_rob`=3; next cycle `alu_flag`=0.
- Dispatch `SUB` with qj_p=1, qj=2 → no issue. LSB CDB rob=2, val=0x100 → issue one cycle after the broadcast with `alu_val1`=0x100.
- Dispatch with qk pending tag 6 while the ALU CDB broadcasts rob=6, val=9 in the same cycle → entry stored ready; issue after the next edge with `alu_val2`=9.
- Dispatch 16 entries all pending tag 1 → `full`=1, and a 17th dispatch is dropped. Broadcast tag 1 → issues in index order 0..15, one per cycle, and `full` drops after the first issue.
- Fill 4 entries, assert `clr` → `alu_flag`=0 from the next cycle, `full`=0, and no later issue. A new dispatch lands in entry 0.
- Assert `rst` asynchronously mid-issue → `alu_flag` drops without a clock edge, and all entries are empty.
